// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receive deframer with scancode FIFO; optional partial-frame timeout under PS2_TIMEOUT_EN
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Line synchronizers and falling-edge detect
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall;
  logic                   bit_in;

  // Shift raw lines through the sync chains; idle-high reset avoids a false edge
  always_ff @(posedge clk) begin
    if (clr) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in = data_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Partial-frame timeout
  // ---------------------------------------------------------------
  state_t state_q, state_d;
  logic   timeout;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;

  // Count idle cycles inside RECV; any ps2_clk falling edge restarts the count
  always_comb begin
    to_d = '0;
    if (state_q == S_RECV && !fall) begin
      to_d = to_q + 1'b1;
    end
  end

  assign timeout = (state_q == S_RECV) && !fall && (to_q == TW'(TIMEOUT_CYC - 1));

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (clr) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       frame_good;

  // Next-state logic: collect start, 8 data bits LSB first, parity, stop; judge in CHECK
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_d     = stop_q;
    frame_good = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall && !bit_in) begin
          cnt_d   = 4'd1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (timeout) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (fall) begin
          if (cnt_q <= 4'd8) begin
            shift_d = {bit_in, shift_q[7:1]};
            cnt_d   = cnt_q + 4'd1;
          end else if (cnt_q == 4'd9) begin
            par_d = bit_in;
            cnt_d = cnt_q + 4'd1;
          end else begin
            stop_d  = bit_in;
            cnt_d   = 4'd0;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        // Odd parity: data bits plus parity bit must contain an odd number of ones
        if ((^shift_q ^ par_q) && stop_q) begin
          frame_good = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and frame shift registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
    end
  end

  // ---------------------------------------------------------------
  // Scancode FIFO
  // ---------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          full;
  logic          pop;
  logic          push;

  assign ready = (fcnt_q != '0);
  assign full  = (fcnt_q == CW'(FIFO_DEPTH));
  assign pop   = ready & ~nextdata_n;
  // A pop in the same cycle frees the slot, so a good frame still lands when full
  assign push  = frame_good & (~full | pop);

  // Pointer, occupancy, last-popped and sticky overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      fcnt_d = fcnt_q + 1'b1;
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - 1'b1;
    end
    if (pop) begin
      ovf_d = 1'b0;
    end else if (frame_good && full) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      last_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only observed while occupied, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data     = ready ? mem_q[rd_ptr_q] : last_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - table-driven bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       clr;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_vec    = 0;
  int n_err    = 0;
  int ferr_cnt = 0;
  int f0;

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) ferr_cnt <= ferr_cnt + 1;

  ps2_rx_fifo #(
    .FIFO_DEPTH (8),
    .SYNC_STAGES(3),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  typedef struct {
    logic       is_pop;
    logic [7:0] d;
    logic       bad;
    logic       e_ready;
    logic [7:0] e_data;
    logic       e_ovf;
    int         e_ferr;
  } vec_t;

  vec_t tab[32];
  int   n_tab = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic [7:0] d, input logic bad,
                     input logic er, input logic [7:0] ed, input logic eo, input int ef);
    tab[n_tab] = '{p, d, bad, er, ed, eo, ef};
    n_tab++;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] d, input logic bad, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
  endtask

  task automatic do_pop();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    clr        = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);

    // Latency: ready rises on the 2nd clk edge after the stop-edge detect cycle
    f0 = ferr_cnt;
    send_head(8'h1C, 1'b0, 10);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk("lat_ready_early", ready, 0);
    @(negedge clk);
    chk("lat_ready", ready, 1);
    chk("lat_data", data, 8'h1C);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("lat_ovf", overflow, 0);
    chk("lat_ferr", ferr_cnt - f0, 0);
    do_pop();
    chk("lat_pop_ready", ready, 0);

    // Vector table
    add(0, 8'hF0, 0, 1, 8'hF0, 0, 0);
    add(0, 8'h1C, 0, 1, 8'hF0, 0, 0);
    add(1, 8'h00, 0, 1, 8'h1C, 0, 0);
    add(1, 8'h00, 0, 0, 8'h1C, 0, 0);
    add(0, 8'h1C, 1, 0, 8'h1C, 0, 1);
    add(0, 8'h12, 0, 1, 8'h12, 0, 0);
    add(1, 8'h00, 0, 0, 8'h12, 0, 0);
    add(1, 8'h00, 0, 0, 8'h12, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 8'(k), 0, 1, 8'h01, (k == 9), 0);
    for (int k = 1; k <= 8; k++) add(1, 8'h00, 0, (k < 8), (k < 8) ? 8'(k + 1) : 8'h08, 0, 0);
    add(1, 8'h00, 0, 0, 8'h08, 0, 0);

    for (int i = 0; i < n_tab; i++) begin
      f0 = ferr_cnt;
      if (tab[i].is_pop) do_pop();
      else send_head(tab[i].d, tab[i].bad, 11);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_ready", i), ready, tab[i].e_ready);
      chk($sformatf("v%0d_data", i), data, tab[i].e_data);
      chk($sformatf("v%0d_ovf", i), overflow, tab[i].e_ovf);
      chk($sformatf("v%0d_ferr", i), ferr_cnt - f0, tab[i].e_ferr);
    end

    // Full FIFO with a pop in the CHECK cycle: write and pop both happen
    for (int k = 0; k < 8; k++) send_head(8'h21 + 8'(k), 1'b0, 11);
    chk("fill_data", data, 8'h21);
    chk("fill_ovf", overflow, 0);
    send_head(8'h2A, 1'b0, 10);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    chk("cpop_ovf", overflow, 0);
    chk("cpop_ready", ready, 1);
    chk("cpop_data", data, 8'h22);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_data", k), data, (k < 7) ? 8'h22 + 8'(k) : 8'h2A);
      do_pop();
    end
    chk("drain_ready", ready, 0);
    chk("drain_ovf", overflow, 0);

    // Reset in mid-frame
    send_head(8'h33, 1'b0, 11);
    chk("pre_rst_ready", ready, 1);
    send_head(8'h58, 1'b0, 5);
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("mrst_ready", ready, 0);
    chk("mrst_data", data, 8'h00);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_ferr", frame_err, 0);
    f0 = ferr_cnt;
    send_head(8'h58, 1'b0, 11);
    repeat (2) @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_data", data, 8'h58);
    chk("post_rst_ferr", ferr_cnt - f0, 0);
    do_pop();

    // Partial frame, long idle, then a full 0x12 frame
    f0 = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    repeat (150) @(negedge clk);
    send_head(8'h12, 1'b0, 11);
    repeat (2) @(negedge clk);
`ifdef PS2_TIMEOUT_EN
    chk("to_ready", ready, 1);
    chk("to_data", data, 8'h12);
    chk("to_ferr", ferr_cnt - f0, 0);
`else
    chk("noto_ready", ready, 0);
    chk("noto_ferr", ferr_cnt - f0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 keyboard receive front end. Samples the raw ps2_clk/ps2_data lines, deframes 11-bit device-to-host frames, and checks start, odd parity and stop bits. Good scancodes are buffered in a small FIFO. It feeds the scancode/keystroke decoder downstream over the data/ready/nextdata_n/overflow handshake.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2
SYNC_STAGES, 3, flip-flop stages on ps2_clk and ps2_data, minimum 2
TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (PS2_TIMEOUT_EN only)

Ports:
clk  in  1  system clock
clr  in  1  reset, synchronous, active-high
ps2_clk  in  1  raw PS/2 clock line, asynchronous
ps2_data  in  1  raw PS/2 data line, asynchronous
nextdata_n  in  1  active-low pop request from the consumer
data  out  8  scancode at the FIFO head
ready  out  1  FIFO not empty
overflow  out  1  a good frame was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse when a frame is discarded (bad start, parity or stop bit)

Behaviour:
- Reset: one clock and one reset; reset is synchronous, active-high (clr).
- On reset: sync chains all 1; FIFO empty; ready=0; overflow=0; frame_err=0; data=8'h00; bit counter 0; state IDLE.
- A reset in mid-frame discards the partial frame. Reception resumes on the next start bit.
- Synchronizer: each line passes through SYNC_STAGES flops. A falling edge is "previous synced ps2_clk = 1, current = 0". ps2_data is sampled from its synced copy in that same cycle.
- FSM IDLE:
  - a falling edge with data=0 records the start bit, sets count=1 and moves to RECV;
  - a falling edge with data=1 is ignored.
- FSM RECV:
  - each falling edge shifts data in LSB first (bits 1..8), then captures parity (bit 9) and stop (bit 10);
  - after bit 10 the FSM moves to CHECK.
- FSM CHECK (one cycle):
  - the frame is good if the XOR of the 8 data bits and the parity bit is 1, and stop=1;
  - good frame: written to the FIFO; next state IDLE;
  - bad frame: frame_err=1 for exactly this cycle, nothing written; next state IDLE.
- Latency: ready rises on the second clk edge after the cycle in which the stop-bit falling edge is detected (one edge into CHECK, one edge for the FIFO write).
- FIFO: write pointer, read pointer and count. data is the head entry, combinational from storage. data equals the last popped value when empty, 8'h00 after reset.
- Pop: occurs on a clk edge where ready=1 and nextdata_n=0. The consumer may hold nextdata_n low on consecutive cycles to drain one entry per cycle.
- Pop on empty: no effect, no error.
- Pointers wrap modulo FIFO_DEPTH.
- Full with a good frame in CHECK and no pop that cycle: the frame is dropped and overflow is set to 1.
- Full with a good frame in CHECK and a pop in the same cycle: the pop and the write both happen, count is unchanged, no overflow.
- overflow is sticky. It clears on the next successful pop and is not set again by that pop cycle.
- frame_err and an overflow event never occur in the same cycle, because CHECK resolves a single frame.

Optional Feature:
PS2_TIMEOUT_EN
- Defined: a counter runs while the FSM is in RECV and resets on every ps2_clk falling edge. On reaching TIMEOUT_CYC the FSM returns to IDLE and the partial frame is discarded silently. frame_err is not pulsed.
- Not defined: no counter; RECV waits indefinitely for the remaining edges, and TIMEOUT_CYC is unused.

Test Plan:
- Frame 0x1C (start 0, data 0x1C LSB first, parity 0, stop 1), nextdata_n=1 -> ready=1, data=8'h1C two clk edges after the stop-bit edge; overflow=0, frame_err=0.
- Frames F0 then 1C, then one pop per ready -> data reads 8'hF0 then 8'h1C; ready=0 after the second pop.
- Frame 0x1C with parity bit 1 -> frame_err is a single one-cycle pulse, ready stays 0; a following good 0x12 (parity 1) is received correctly.
- FIFO_DEPTH=8: send 9 good frames 0x01..0x09 with no pops -> overflow=1 after the 9th; draining reads 0x01..0x08 only; overflow=0 after the first pop. Then fill to 8, send a 10th frame with nextdata_n low in its CHECK cycle -> no overflow, count stays 8.
- Assert clr after 5 bits of a frame -> all outputs at reset values; a following frame 0x58 is received intact.
- PS2_TIMEOUT_EN, TIMEOUT_CYC=100: 4 bits, then 150 idle cycles, then full frame 0x12 -> data=8'h12, frame_err never pulses. Without the macro, the same stimulus yields a misaligned frame and a frame_err pulse.
